alu_operand_sequencer: RTL and testbench

//  Upstream operand loader for the 8-bit ALU; also captures the ALU result.

---
 rtl/alu_operand_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_operand_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand loader for the 8-bit ALU: takes A, B and opcode bytes, then captures Result/Cout.
// Optional ALU_SEQ_ZERO_FLAG_EN adds a registered out_zero flag captured with out_data.
module alu_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout,
    output logic             out_valid,
    output logic             busy,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic             err
);

    // Keep the counter at least one bit wide when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, GOT_A, GOT_B, EXEC} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             accept;
    logic             waiting;
    logic             timeout_hit;
    logic             ld_a, ld_b, ld_sel, capture;

    // Accept is derived from state directly so it does not loop through in_ready.
    assign accept      = in_valid && (state != EXEC);
    assign waiting     = (state == GOT_A) || (state == GOT_B);
    assign timeout_hit = (TIMEOUT != 0) && waiting && !accept
                         && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = GOT_A;
            GOT_A:   if (accept) state_nxt = GOT_B;
                     else if (timeout_hit) state_nxt = IDLE;
            GOT_B:   if (accept) state_nxt = EXEC;
                     else if (timeout_hit) state_nxt = IDLE;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != EXEC);
        busy     = (state != IDLE);
        ld_a     = accept && (state == IDLE);
        ld_b     = accept && (state == GOT_A);
        ld_sel   = accept && (state == GOT_B);
        capture  = (state == EXEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept || !waiting || timeout_hit) begin
            tmo_cnt <= '0;
        end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            out_data  <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (ld_a)   alu_a   <= in_data;
            if (ld_b)   alu_b   <= in_data;
            if (ld_sel) alu_sel <= in_data[SEL_W-1:0];
            if (capture) begin
                out_data <= alu_result;
                out_cout <= alu_cout;
            end
            out_valid <= capture;
            if (timeout_hit) begin
                err <= 1'b1;
            end else if (ld_a) begin
                err <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_zero <= 1'b0;
        end else if (capture) begin
            out_zero <= (alu_result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small behavioural ALU (sel=0 is A+B).
// Build with ALU_SEQ_ZERO_FLAG_EN defined to also cover out_zero.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic [7:0] out_data;
    logic       out_cout, out_valid, busy, err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.WIDTH(8), .SEL_W(3), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .out_data   (out_data),
        .out_cout   (out_cout),
        .out_valid  (out_valid),
        .busy       (busy),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .out_zero   (out_zero),
`endif
        .err        (err)
    );

    logic [8:0] wide;
    always_comb begin
        wide = '0;
        case (alu_sel)
            3'd0:    wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2:    wide = {1'b0, alu_a & alu_b};
            3'd3:    wide = {1'b0, alu_a | alu_b};
            default: wide = {1'b0, alu_a ^ alu_b};
        endcase
        alu_result = wide[7:0];
        alu_cout   = wide[8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its EXEC cycle with in_valid low.
    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        in_valid = 1'b1;
        in_data  = a;  tick;
        in_data  = b;  tick;
        in_data  = op; tick;
        in_valid = 1'b0;
    endtask

    initial begin
        // 1: asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        check("rst_alu_a",     alu_a,     0);
        check("rst_alu_b",     alu_b,     0);
        check("rst_alu_sel",   alu_sel,   0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_cout",  out_cout,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err",       err,       0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("rst_out_zero",  out_zero,  0);
`endif
        tick; tick;
        rst = 1'b0;
        tick;
        check("rel_in_ready", in_ready, 1);
        check("rel_busy",     busy,     0);

        // 2: 0x0F + 0x01
        in_valid = 1'b1; in_data = 8'h0F; tick;
        check("t2_alu_a", alu_a, 8'h0F);
        check("t2_busy_a", busy, 1);
        in_data = 8'h01; tick;
        check("t2_alu_b", alu_b, 8'h01);
        in_data = 8'h00; tick;
        in_valid = 1'b0;
        check("t2_alu_sel",   alu_sel,   0);
        check("t2_exec_rdy",  in_ready,  0);
        check("t2_exec_busy", busy,      1);
        check("t2_exec_ov",   out_valid, 0);
        tick;
        check("t2_ov",    out_valid, 1);
        check("t2_data",  out_data,  8'h10);
        check("t2_cout",  out_cout,  0);
        check("t2_busy",  busy,      0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("t2_zero",  out_zero,  0);
`endif
        tick;
        check("t2_ov_drop", out_valid, 0);
        check("t2_hold",    out_data,  8'h10);

        // 3: 0xFF + 0x01 with opcode upper bits set
        send3(8'hFF, 8'h01, 8'hF8);
        check("t3_sel", alu_sel, 0);
        tick;
        check("t3_ov",   out_valid, 1);
        check("t3_data", out_data,  8'h00);
        check("t3_cout", out_cout,  1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("t3_zero", out_zero,  1);
`endif
        tick;

        // 4: timeout after 4 idle cycles in GOT_A
        in_valid = 1'b1; in_data = 8'h22; tick;
        in_valid = 1'b0;
        tick; tick; tick;
        check("t4_busy_3idle", busy, 1);
        check("t4_err_3idle",  err,  0);
        tick;
        check("t4_busy", busy,      0);
        check("t4_err",  err,       1);
        check("t4_data", out_data,  8'h00);
        check("t4_cout", out_cout,  1);
        check("t4_ov",   out_valid, 0);
        tick;
        check("t4_err_sticky", err, 1);
        in_valid = 1'b1; in_data = 8'h05; tick;
        check("t4_new_a",  alu_a, 8'h05);
        check("t4_err_clr", err,  0);
        in_data = 8'h03; tick;
        in_data = 8'h00; tick;
        in_valid = 1'b0;
        tick;
        check("t4_result", out_data, 8'h08);

        // 5: reset while in GOT_B
        in_valid = 1'b1; in_data = 8'h10; tick;
        in_data = 8'h20; tick;
        in_valid = 1'b0;
        check("t5_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy",  busy,     0);
        check("t5_data",  out_data, 0);
        check("t5_alu_a", alu_a,    0);
        check("t5_rdy",   in_ready, 1);
        tick;
        rst = 1'b0;
        send3(8'h30, 8'h12, 8'h00);
        tick;
        check("t5_ov",   out_valid, 1);
        check("t5_data2", out_data, 8'h42);

        // 6: byte held through EXEC is taken as next A while out_valid pulses
        tick;
        send3(8'h07, 8'h08, 8'h00);
        in_valid = 1'b1; in_data = 8'hAA;
        #1;
        check("t6_exec_rdy", in_ready, 0);
        check("t6_exec_a",   alu_a,    8'h07);
        tick;
        check("t6_ov",    out_valid, 1);
        check("t6_data",  out_data,  8'h0F);
        check("t6_rdy",   in_ready,  1);
        check("t6_a_hold", alu_a,    8'h07);
        tick;
        in_valid = 1'b0;
        check("t6_new_a", alu_a,     8'hAA);
        check("t6_busy",  busy,      1);
        check("t6_ov2",   out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
